// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb: sequences and arbitrates the single register-file write port.
// Requesters, highest priority first: pipeline writeback (WB), the interrupt
// return-address save latch (IRQ), and an in-order FIFO of mult/div results (MDU).
// A small scoreboard reports registers that still have an IRQ or MDU write pending.
// Optional starvation guard: define REGARB_STARVE_GUARD_EN to enable stall_req.
//
// The MDU FIFO is kept compacted with slot 0 as the head. A WB write that kills
// an entry in the middle therefore leaves no hole, so the oldest surviving result
// is always at the head and the occupancy count covers live entries only.

module regfile_wr_arb #(
  parameter logic [4:0] IRQ_REG      = 5'd31,
  parameter int         FIFO_DEPTH   = 2,
  parameter int         STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  input  logic        irq,
  input  logic [31:0] irq_pc,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_addr,
  input  logic [31:0] mdu_data,
  input  logic [4:0]  id_addr_a,
  input  logic [4:0]  id_addr_b,
  output logic        busy_a,
  output logic        busy_b,
  output logic        irq_busy,
  output logic        stall_req,
  output logic        rf_we,
  output logic [4:0]  rf_addr,
  output logic [31:0] rf_data
);

  localparam int               CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic              irq_full;
  logic [31:0]       irq_data;
  logic [4:0]        fifo_addr [FIFO_DEPTH];
  logic [31:0]       fifo_data [FIFO_DEPTH];
  logic [CNT_W-1:0]  fifo_cnt;

  logic [4:0]        nxt_addr [FIFO_DEPTH];
  logic [31:0]       nxt_data [FIFO_DEPTH];
  logic [CNT_W-1:0]  nxt_cnt;

  logic              wb_ok;
  logic              gnt_irq;
  logic              gnt_fifo;
  logic              irq_kill;
  logic              irq_cap;
  logic              push;

  logic              sel_we;
  logic [4:0]        sel_addr;
  logic [31:0]       sel_data;

  // Writes to $0 are swallowed here so they never win a grant or kill anything.
  assign wb_ok     = wb_we && (wb_addr != 5'd0);
  assign gnt_irq   = !wb_ok && irq_full;
  assign gnt_fifo  = !wb_ok && !irq_full && (fifo_cnt != '0);
  assign mdu_ready = (fifo_cnt < DEPTH_C);
  assign irq_busy  = irq_full;

  // A newer WB write to the latched register supersedes the saved return address,
  // and a same-cycle capture aimed at that register is suppressed for the same reason.
  assign irq_kill = wb_ok && (wb_addr == IRQ_REG);
  assign irq_cap  = irq && !irq_pc[31] && !irq_full && !irq_kill && (IRQ_REG != 5'd0);

  // A result whose address is being overwritten by WB this cycle is already stale.
  assign push = mdu_valid && mdu_ready && (mdu_addr != 5'd0) &&
                !(wb_ok && (mdu_addr == wb_addr));

  // Next FIFO contents: drop the popped head and killed entries, compact, then append.
  always_comb begin
    nxt_addr = fifo_addr;
    nxt_data = fifo_data;
    nxt_cnt  = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if ((CNT_W'(i) < fifo_cnt) && !(gnt_fifo && (i == 0)) &&
          !(wb_ok && (fifo_addr[i] == wb_addr))) begin
        nxt_addr[nxt_cnt] = fifo_addr[i];
        nxt_data[nxt_cnt] = fifo_data[i];
        nxt_cnt           = nxt_cnt + CNT_W'(1);
      end
    end
    if (push) begin
      nxt_addr[nxt_cnt] = mdu_addr;
      nxt_data[nxt_cnt] = mdu_data;
      nxt_cnt           = nxt_cnt + CNT_W'(1);
    end
  end

  // Select the single winner for this cycle's write.
  always_comb begin
    sel_we   = 1'b0;
    sel_addr = 5'd0;
    sel_data = 32'd0;
    if (wb_ok) begin
      sel_we   = 1'b1;
      sel_addr = wb_addr;
      sel_data = wb_data;
    end else if (gnt_irq) begin
      sel_we   = 1'b1;
      sel_addr = IRQ_REG;
      sel_data = irq_data;
    end else if (gnt_fifo) begin
      sel_we   = 1'b1;
      sel_addr = fifo_addr[0];
      sel_data = fifo_data[0];
    end
  end

  // Scoreboard: a register is busy while the IRQ latch or a live FIFO slot targets it.
  always_comb begin
    busy_a = irq_full && (id_addr_a == IRQ_REG);
    busy_b = irq_full && (id_addr_b == IRQ_REG);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (CNT_W'(i) < fifo_cnt) begin
        busy_a = busy_a | (fifo_addr[i] == id_addr_a);
        busy_b = busy_b | (fifo_addr[i] == id_addr_b);
      end
    end
    if (id_addr_a == 5'd0) busy_a = 1'b0;
    if (id_addr_b == 5'd0) busy_b = 1'b0;
  end

  // IRQ save latch: load the return address (PC+4 within 31 bits, kernel flag kept).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_full <= 1'b0;
      irq_data <= 32'd0;
    end else if (irq_cap) begin
      irq_full <= 1'b1;
      irq_data <= {irq_pc[31], irq_pc[30:0] + 31'd4};
    end else if (gnt_irq || irq_kill) begin
      irq_full <= 1'b0;
    end
  end

  // MDU FIFO storage and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr[i] <= 5'd0;
        fifo_data[i] <= 32'd0;
      end
    end else begin
      fifo_cnt  <= nxt_cnt;
      fifo_addr <= nxt_addr;
      fifo_data <= nxt_data;
    end
  end

  // Registered write port: the winner appears one clock after it is granted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we   <= 1'b0;
      rf_addr <= 5'd0;
      rf_data <= 32'd0;
    end else begin
      rf_we   <= sel_we;
      rf_addr <= sel_addr;
      rf_data <= sel_data;
    end
  end

`ifdef REGARB_STARVE_GUARD_EN
  localparam int            SW      = $clog2(STARVE_LIMIT + 2);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);
  localparam logic [SW-1:0] SAT_C   = SW'(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_cnt;
  logic          pending;

  assign pending   = irq_full || (fifo_cnt != '0);
  assign stall_req = (starve_cnt == LIMIT_C);

  // Count cycles that WB denies a waiting entry; saturating past the limit keeps stall_req a single pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (!pending || gnt_irq || gnt_fifo) begin
      starve_cnt <= '0;
    end else if (wb_ok && (starve_cnt != SAT_C)) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end
`else
  assign stall_req = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wr_arb.sv
// tb_regfile_wr_arb: directed scenarios followed by random traffic, every cycle
// compared against a queue-based reference model of the write-port arbiter.

module tb_regfile_wr_arb;

  localparam int FIFO_DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        irq;
  logic [31:0] irq_pc;
  logic        mdu_valid;
  logic        mdu_ready;
  logic [4:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic [4:0]  id_addr_a;
  logic [4:0]  id_addr_b;
  logic        busy_a;
  logic        busy_b;
  logic        irq_busy;
  logic        stall_req;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;

  always #5 clk = ~clk;

  regfile_wr_arb dut (
    .clk(clk), .reset(reset),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .irq(irq), .irq_pc(irq_pc),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
    .id_addr_a(id_addr_a), .id_addr_b(id_addr_b),
    .busy_a(busy_a), .busy_b(busy_b), .irq_busy(irq_busy), .stall_req(stall_req),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data)
  );

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  entry_t      mdl_fifo[$];
  logic        mdl_irq_full;
  logic [31:0] mdl_irq_data;
  logic        exp_we;
  logic [4:0]  exp_addr;
  logic [31:0] exp_data;
  int          checks = 0;
  int          passed = 0;
  int          failed = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic mdlBusy(input logic [4:0] id);
    if (id == 5'd0) return 1'b0;
    if (mdl_irq_full && id == 5'd31) return 1'b1;
    foreach (mdl_fifo[i]) if (mdl_fifo[i].addr == id) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelReset();
    mdl_fifo.delete();
    mdl_irq_full = 1'b0;
    mdl_irq_data = 32'd0;
  endtask

  // One clock of the reference: priority grant, WAW kill, IRQ capture, MDU push.
  task automatic modelStep();
    logic   wb_ok;
    logic   cap;
    logic   ready;
    entry_t kept[$];
    entry_t e;
    wb_ok = wb_we && (wb_addr != 5'd0);
    ready = (mdl_fifo.size() < FIFO_DEPTH);
    cap   = irq && !irq_pc[31] && !mdl_irq_full && !(wb_ok && wb_addr == 5'd31);
    exp_we = 1'b0; exp_addr = 5'd0; exp_data = 32'd0;
    if (wb_ok) begin
      exp_we = 1'b1; exp_addr = wb_addr; exp_data = wb_data;
    end else if (mdl_irq_full) begin
      exp_we = 1'b1; exp_addr = 5'd31; exp_data = mdl_irq_data;
      mdl_irq_full = 1'b0;
    end else if (mdl_fifo.size() > 0) begin
      e = mdl_fifo.pop_front();
      exp_we = 1'b1; exp_addr = e.addr; exp_data = e.data;
    end
    if (wb_ok) begin
      if (wb_addr == 5'd31) mdl_irq_full = 1'b0;
      foreach (mdl_fifo[i]) if (mdl_fifo[i].addr != wb_addr) kept.push_back(mdl_fifo[i]);
      mdl_fifo = kept;
    end
    if (cap) begin
      mdl_irq_full = 1'b1;
      mdl_irq_data = (irq_pc + 32'd4) & 32'h7FFF_FFFF;
    end
    if (mdu_valid && ready && mdu_addr != 5'd0 && !(wb_ok && wb_addr == mdu_addr)) begin
      e.addr = mdu_addr;
      e.data = mdu_data;
      mdl_fifo.push_back(e);
    end
  endtask

  // Drive one cycle of inputs, check state-derived outputs, clock, check the write port.
  task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic iq, input logic [31:0] pc,
                               input logic mv, input logic [4:0] ma, input logic [31:0] md,
                               input logic [4:0] ia, input logic [4:0] ib);
    @(negedge clk);
    wb_we = we; wb_addr = wa; wb_data = wd;
    irq = iq; irq_pc = pc;
    mdu_valid = mv; mdu_addr = ma; mdu_data = md;
    id_addr_a = ia; id_addr_b = ib;
    #1;
    checkOutput("mdu_ready", mdu_ready, mdl_fifo.size() < FIFO_DEPTH);
    checkOutput("busy_a", busy_a, mdlBusy(id_addr_a));
    checkOutput("busy_b", busy_b, mdlBusy(id_addr_b));
    checkOutput("irq_busy", irq_busy, mdl_irq_full);
    checkOutput("stall_req", stall_req, 1'b0);
    modelStep();
    @(posedge clk);
    #1;
    checkOutput("rf_we", rf_we, exp_we);
    if (exp_we) begin
      checkOutput("rf_addr", rf_addr, exp_addr);
      checkOutput("rf_data", rf_data, exp_data);
    end
  endtask

  task automatic idle(input logic [4:0] ia);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, ia, 5'd0);
  endtask

  function automatic logic [4:0] randAddr();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 5'd31 : 5'(r);
  endfunction

  initial begin
    reset = 1'b0;
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    irq = 1'b0; irq_pc = 32'd0;
    mdu_valid = 1'b0; mdu_addr = 5'd0; mdu_data = 32'd0;
    id_addr_a = 5'd31; id_addr_b = 5'd1;
    modelReset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_rf_we", rf_we, 1'b0);
    checkOutput("rst_rf_addr", rf_addr, 5'd0);
    checkOutput("rst_rf_data", rf_data, 32'd0);
    checkOutput("rst_mdu_ready", mdu_ready, 1'b1);
    checkOutput("rst_busy_a", busy_a, 1'b0);
    checkOutput("rst_irq_busy", irq_busy, 1'b0);
    checkOutput("rst_stall_req", stall_req, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // IRQ save, kernel-mode ignore, and 31-bit wrap of the return address
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 32'h0000_1000, 1'b0, 5'd0, 32'd0, 5'd31, 5'd0);
    idle(5'd31);
    checkOutput("irq_we", rf_we, 1'b1);
    checkOutput("irq_addr", rf_addr, 5'd31);
    checkOutput("irq_data", rf_data, 32'h0000_1004);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 32'h8000_1000, 1'b0, 5'd0, 32'd0, 5'd31, 5'd0);
    idle(5'd31);
    checkOutput("irq_kernel_no_we", rf_we, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b1, 32'h7FFF_FFFC, 1'b0, 5'd0, 32'd0, 5'd31, 5'd0);
    idle(5'd31);
    checkOutput("irq_wrap_data", rf_data, 32'h0000_0000);

    // Same-cycle IRQ capture and WB to the IRQ register
    applyStimulus(1'b1, 5'd31, 32'hDEAD_BEEF, 1'b1, 32'h0000_2000, 1'b0, 5'd0, 32'd0, 5'd31, 5'd0);
    checkOutput("irqwb_data", rf_data, 32'hDEAD_BEEF);
    idle(5'd31);
    checkOutput("irqwb_no_later_we", rf_we, 1'b0);

    // Priority and FIFO full
    applyStimulus(1'b1, 5'd1, 32'hA1, 1'b0, 32'd0, 1'b1, 5'd8, 32'h11, 5'd9, 5'd8);
    applyStimulus(1'b1, 5'd2, 32'hA2, 1'b0, 32'd0, 1'b1, 5'd9, 32'h22, 5'd9, 5'd8);
    checkOutput("full_mdu_ready", mdu_ready, 1'b0);
    checkOutput("full_busy_a", busy_a, 1'b1);
    applyStimulus(1'b1, 5'd3, 32'hA3, 1'b0, 32'd0, 1'b1, 5'd10, 32'h33, 5'd9, 5'd8);
    idle(5'd9);
    checkOutput("fifo_first_addr", rf_addr, 5'd8);
    checkOutput("fifo_first_data", rf_data, 32'h11);
    idle(5'd9);
    checkOutput("fifo_second_addr", rf_addr, 5'd9);
    checkOutput("fifo_second_data", rf_data, 32'h22);

    // WAW kill of a queued MDU result
    applyStimulus(1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b1, 5'd7, 32'h99, 5'd7, 5'd0);
    applyStimulus(1'b1, 5'd7, 32'h55, 1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
    checkOutput("waw_data", rf_data, 32'h55);
    checkOutput("waw_busy_drop", busy_a, 1'b0);
    idle(5'd7);
    checkOutput("waw_no_stale_we", rf_we, 1'b0);

    // Reset asserted mid-cycle with a pending MDU entry
    applyStimulus(1'b1, 5'd4, 32'h44, 1'b0, 32'd0, 1'b1, 5'd5, 32'h66, 5'd5, 5'd0);
    checkOutput("pre_rst_busy_a", busy_a, 1'b1);
    #2;
    reset = 1'b0;
    wb_we = 1'b0; irq = 1'b0; mdu_valid = 1'b0;
    #1;
    checkOutput("midrst_rf_we", rf_we, 1'b0);
    checkOutput("midrst_busy_a", busy_a, 1'b0);
    checkOutput("midrst_mdu_ready", mdu_ready, 1'b1);
    modelReset();
    @(negedge clk);
    reset = 1'b1;

    // Random traffic over a small address set to provoke collisions
    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), randAddr(), $urandom(),
                    ($urandom_range(0, 3) == 0), {1'($urandom_range(0, 3) == 0), 31'($urandom())},
                    1'($urandom_range(0, 1)), randAddr(), $urandom(),
                    randAddr(), randAddr());
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
